// File: rtl/tff_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tff_arb_pkg
// Brief    : Shared types, sizes and the round-robin pick function for the
//            toggle-bank arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package tff_arb_pkg;

  // Two-state arbitration FSM
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_t;

  // Index registers are sized for the largest supported requester count so
  // the pick function has one fixed signature for every N_REQ.
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = $clog2(MAX_REQ);

  // First set request at or after ptr, wrapping modulo n_req.
  // Returns 0 when nothing is requested (the caller qualifies with |req).
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [IDX_W-1:0]   ptr,
    input int                 n_req
  );
    logic [IDX_W:0] j;
    logic           found;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      // ptr < n_req and k < n_req, so one subtraction wraps the sum
      j = {1'b0, ptr} + (IDX_W+1)'(k);
      if (j >= (IDX_W+1)'(n_req)) begin
        j = j - (IDX_W+1)'(n_req);
      end
      if ((k < n_req) && !found && req[j[IDX_W-1:0]]) begin
        rr_pick = j[IDX_W-1:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/tff_bank.sv
`default_nettype none
// ============================================================================
// Module   : tff_bank
// Brief    : WIDTH toggle flip-flops. Bit i toggles when en & t[i]; a
//            synchronous clear wins over any toggle in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tff_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,    // asynchronous, active-low
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] bank_q;
  logic [WIDTH-1:0] bank_d;

  // Next bank value: clear first, then the masked toggle
  always_comb begin
    bank_d = bank_q;
    if (clr) begin
      bank_d = '0;
    end else if (en) begin
      bank_d = bank_q ^ t;
    end
  end

  // Bank storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q <= '0;
    end else begin
      bank_q <= bank_d;
    end
  end

  assign q = bank_q;

endmodule
`default_nettype wire

// File: rtl/tff_toggle_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tff_toggle_arbiter
// Brief    : Round-robin arbiter serialising N_REQ toggle masks onto one
//            shared bank of WIDTH T flip-flops. One grant per two cycles:
//            IDLE captures winner and mask, APPLY pulses gnt and toggles.
// Config   : TFF_ARB_GRANT_COUNT_EN adds a saturating 16-bit grant counter
//            output (grant_cnt).
// Revision : 1.0 - initial release
// ============================================================================
module tff_toggle_arbiter #(
  parameter int N_REQ = 4,   // 2..8
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,    // asynchronous, active-low
  input  logic                   clr,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] mask,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic                   busy
`ifdef TFF_ARB_GRANT_COUNT_EN
  ,
  output logic [15:0]            grant_cnt
`endif
);

  import tff_arb_pkg::*;

  state_t           state_q,    state_d;
  logic [IDX_W-1:0] idx_q,      idx_d;
  logic [IDX_W-1:0] rr_ptr_q,   rr_ptr_d;
  logic [WIDTH-1:0] mask_cap_q, mask_cap_d;
  logic [N_REQ-1:0] gnt_q,      gnt_d;
  logic             busy_q,     busy_d;

  logic [MAX_REQ-1:0] w_req_pad;
  logic [IDX_W-1:0]   w_pick;
  logic [WIDTH-1:0]   w_mask_sel;
  logic               w_apply_en;

  // Round-robin winner and its mask slice
  always_comb begin
    w_req_pad             = '0;
    w_req_pad[N_REQ-1:0]  = req;
    w_pick                = rr_pick(w_req_pad, rr_ptr_q, N_REQ);
    w_mask_sel            = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick == IDX_W'(i)) begin
        w_mask_sel = mask[i*WIDTH +: WIDTH];
      end
    end
  end

  // FSM next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rr_ptr_d   = rr_ptr_q;
    mask_cap_d = mask_cap_q;
    gnt_d      = '0;
    busy_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d    = ST_APPLY;
          idx_d      = w_pick;
          mask_cap_d = w_mask_sel;
          busy_d     = 1'b1;
          // grant is registered so it is high exactly during APPLY
          for (int i = 0; i < N_REQ; i++) begin
            gnt_d[i] = (w_pick == IDX_W'(i));
          end
        end
      end
      ST_APPLY: begin
        state_d  = ST_IDLE;
        rr_ptr_d = (idx_q == IDX_W'(N_REQ-1)) ? '0 : idx_q + 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      rr_ptr_q   <= '0;
      mask_cap_q <= '0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rr_ptr_q   <= rr_ptr_d;
      mask_cap_q <= mask_cap_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
    end
  end

  assign w_apply_en = (state_q == ST_APPLY);
  assign gnt        = gnt_q;
  assign busy       = busy_q;

  tff_bank #(
    .WIDTH (WIDTH)
  ) u_bank (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (w_apply_en),
    .t   (mask_cap_q),
    .q   (q)
  );

`ifdef TFF_ARB_GRANT_COUNT_EN
  logic [15:0] grant_cnt_q, grant_cnt_d;

  // Saturating count of APPLY cycles; clr leaves it alone
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    if (w_apply_en && (grant_cnt_q != 16'hFFFF)) begin
      grant_cnt_d = grant_cnt_q + 16'd1;
    end
  end

  // Grant counter storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign grant_cnt = grant_cnt_q;
`endif

endmodule
`default_nettype wire
